cache_fill_arbiter: RTL and testbench

- Sequences cache-block refills from the single shared main memory for the pipelined CPU.
- Arbitrates between the I-cache (fetch stage) and D-cache (memory stage) miss requests.
- For the granted requester: issues one word read per cycle, counts returned words, steers each one into that cache's data array, then writes the tag and signals completion.

---
 rtl/cache_pkg.sv | 15 +
 rtl/cache_fill_arbiter_if.sv | 35 +++
 rtl/fill_word_counter.sv | 26 ++
 rtl/cache_fill_arbiter.sv | 100 ++++++++++
 tb/tb_cache_fill_arbiter.sv | 164 ++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// Shared cache refill types and constants, also used by the cache tag logic.
package cache_pkg;

  localparam int WORDS_PER_BLOCK = 8;
  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'(2 * WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} fill_state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  function automatic logic [15:0] blockBase(input logic [15:0] addr,
                                            input logic [15:0] offMask = BLOCK_OFFSET_MASK);
    return addr & ~offMask;
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_if.sv
// Miss-request, main-memory read and cache-fill signals of the refill arbiter.
interface cache_fill_arbiter_if import cache_pkg::*;
  #(parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK) ();

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);

  logic              icache_miss;
  logic [15:0]       icache_miss_addr;
  logic              dcache_miss;
  logic [15:0]       dcache_miss_addr;
  logic              mem_en;
  logic [15:0]       mem_addr;
  logic              mem_data_valid;
  logic              fill_we_i;
  logic              fill_we_d;
  logic [IDX_W-1:0]  fill_word_idx;
  logic              fill_tag_we_i;
  logic              fill_tag_we_d;
  logic              fill_done_i;
  logic              fill_done_d;
  logic              busy;

  modport master (
    input  icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr, mem_data_valid,
    output mem_en, mem_addr, fill_we_i, fill_we_d, fill_word_idx,
           fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d, busy
  );

  modport slave (
    output icache_miss, icache_miss_addr, dcache_miss, dcache_miss_addr, mem_data_valid,
    input  mem_en, mem_addr, fill_we_i, fill_we_d, fill_word_idx,
           fill_tag_we_i, fill_tag_we_d, fill_done_i, fill_done_d, busy
  );

endinterface

// File: rtl/fill_word_counter.sv
// Word counter for one refill: clears, counts up without wrapping, flags the last word.
module fill_word_counter #(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               clear,
  input  logic                               inc,
  output logic [$clog2(WORDS_PER_BLOCK):0]   cnt,
  output logic                               last,
  output logic                               full
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W + 1)'(WORDS_PER_BLOCK - 1);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(WORDS_PER_BLOCK);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) cnt <= '0;
    else if (inc && !full) cnt <= cnt + 1'b1;
  end

  assign last = (cnt == LAST_CNT);
  assign full = (cnt == FULL_CNT);

endmodule

// File: rtl/cache_fill_arbiter.sv
// Refill sequencer: grants I- or D-cache misses (D first), streams a block from
// main memory into the owner's data array, then writes its tag.
//
// state | meaning
// IDLE  | no fill; arbitrate pending misses
// ISSUE | one memory read per cycle, words may already return
// DRAIN | all reads issued, collecting remaining words
// DONE  | tag write + completion pulse for the owner
module cache_fill_arbiter import cache_pkg::*; #(
  parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK
) (
  input  logic           clk,
  input  logic           rst_n,
  cache_fill_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(WORDS_PER_BLOCK);
  localparam logic [15:0] OFF_MASK = 16'(2 * WORDS_PER_BLOCK - 1);

  fill_state_t       state, stateNext;
  owner_t            owner;
  logic [15:0]       base;
  logic [IDX_W:0]    issueCnt, recvCnt;
  logic              issueLast, recvLast, issueFull, recvFull;
  logic              grant, recvFire, inFill;

  assign grant    = (state == IDLE) && (bus.dcache_miss || bus.icache_miss);
  assign inFill   = (state == ISSUE) || (state == DRAIN);
  assign recvFire = inFill && bus.mem_data_valid && !recvFull;

  fill_word_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) uIssueCnt (
    .clk(clk), .rst_n(rst_n), .clear(state == IDLE), .inc(state == ISSUE),
    .cnt(issueCnt), .last(issueLast), .full(issueFull)
  );

  fill_word_counter #(.WORDS_PER_BLOCK(WORDS_PER_BLOCK)) uRecvCnt (
    .clk(clk), .rst_n(rst_n), .clear(state == IDLE), .inc(recvFire),
    .cnt(recvCnt), .last(recvLast), .full(recvFull)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // D-cache has fixed priority; the stalled pipeline cannot raise a new D miss during an I fill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner <= OWN_I;
      base  <= '0;
    end else if (grant) begin
      owner <= bus.dcache_miss ? OWN_D : OWN_I;
      base  <= bus.dcache_miss ? blockBase(bus.dcache_miss_addr, OFF_MASK)
                               : blockBase(bus.icache_miss_addr, OFF_MASK);
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:  if (grant) stateNext = ISSUE;
      ISSUE: begin
        if (recvFire && recvLast) stateNext = DONE;
        else if (issueLast)       stateNext = DRAIN;
      end
      DRAIN: if (recvFire && recvLast) stateNext = DONE;
      DONE:  stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_en        = 1'b0;
    bus.mem_addr      = '0;
    bus.fill_we_i     = 1'b0;
    bus.fill_we_d     = 1'b0;
    bus.fill_word_idx = '0;
    bus.fill_tag_we_i = 1'b0;
    bus.fill_tag_we_d = 1'b0;
    bus.fill_done_i   = 1'b0;
    bus.fill_done_d   = 1'b0;
    bus.busy          = (state != IDLE);
    if (state == ISSUE && !issueFull) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = base + 16'({issueCnt, 1'b0});
    end
    if (recvFire) begin
      bus.fill_we_i     = (owner == OWN_I);
      bus.fill_we_d     = (owner == OWN_D);
      bus.fill_word_idx = recvCnt[IDX_W-1:0];
    end
    if (state == DONE) begin
      bus.fill_tag_we_i = (owner == OWN_I);
      bus.fill_tag_we_d = (owner == OWN_D);
      bus.fill_done_i   = (owner == OWN_I);
      bus.fill_done_d   = (owner == OWN_D);
    end
  end

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with 8-word blocks and hand-computed expectations.
module tb_cache_fill_arbiter;
  import cache_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cache_fill_arbiter_if busIf ();
  cache_fill_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(busIf));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rangeMask(input int lo, input int hi);
    logic [31:0] m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  task automatic checkQuiet(input string tag);
    chk({tag, "_ctl"}, 32'({busIf.mem_en, busIf.fill_we_i, busIf.fill_we_d,
                            busIf.fill_tag_we_i, busIf.fill_tag_we_d,
                            busIf.fill_done_i, busIf.fill_done_d, busIf.busy}), 32'h0);
    chk({tag, "_addr"}, 32'(busIf.mem_addr), 32'h0);
  endtask

  // Caller has the miss asserted in the current IDLE cycle (cycle 0). Bit c of
  // validMask drives mem_data_valid in cycle c. Expected: 8 reads in cycles 1..8,
  // DONE in the cycle after the 8th valid, IDLE (miss dropped) the cycle after.
  task automatic runFill(input string tag, input bit isD, input logic [15:0] expBase,
                         input logic [31:0] validMask);
    int   recv = 0;
    int   doneCyc = 0;
    logic expWe, expBusy, weOwn, tagOwn, doneOwn;
    logic [2:0] other;
    chk({tag, "_c0_busy"}, 32'(busIf.busy), 32'h0);
    for (int c = 1; c < 32; c++) begin
      @(posedge clk); #1;
      busIf.mem_data_valid = validMask[c];
      if (doneCyc != 0 && c == doneCyc + 1) begin
        if (isD) busIf.dcache_miss = 1'b0;
        else     busIf.icache_miss = 1'b0;
      end
      #1;
      expWe   = (doneCyc == 0) && validMask[c];
      expBusy = (doneCyc == 0) || (c <= doneCyc);
      weOwn   = isD ? busIf.fill_we_d     : busIf.fill_we_i;
      tagOwn  = isD ? busIf.fill_tag_we_d : busIf.fill_tag_we_i;
      doneOwn = isD ? busIf.fill_done_d   : busIf.fill_done_i;
      other   = isD ? {busIf.fill_we_i, busIf.fill_tag_we_i, busIf.fill_done_i}
                    : {busIf.fill_we_d, busIf.fill_tag_we_d, busIf.fill_done_d};
      chk({tag, "_busy"}, 32'(busIf.busy), 32'(expBusy));
      chk({tag, "_mem_en"}, 32'(busIf.mem_en), 32'(c <= 8));
      chk({tag, "_mem_addr"}, 32'(busIf.mem_addr),
          (c <= 8) ? 32'(expBase + 16'(2 * (c - 1))) : 32'h0);
      chk({tag, "_we"}, 32'(weOwn), 32'(expWe));
      chk({tag, "_nonowner"}, 32'(other), 32'h0);
      chk({tag, "_tag_we"}, 32'(tagOwn), 32'(doneCyc != 0 && c == doneCyc));
      chk({tag, "_done"}, 32'(doneOwn), 32'(doneCyc != 0 && c == doneCyc));
      if (expWe) begin
        chk({tag, "_idx"}, 32'(busIf.fill_word_idx), 32'(recv));
        recv++;
        if (recv == 8) doneCyc = c + 1;
      end
      if (doneCyc != 0 && c == doneCyc + 1) break;
    end
    busIf.mem_data_valid = 1'b0;
    chk({tag, "_done_seen"}, 32'(doneCyc != 0), 32'h1);
  endtask

  initial begin
    rst_n = 1'b0;
    busIf.icache_miss = 1'b0;
    busIf.icache_miss_addr = '0;
    busIf.dcache_miss = 1'b0;
    busIf.dcache_miss_addr = '0;
    busIf.mem_data_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    checkQuiet("reset");

    // I miss only, latency 4
    @(posedge clk); #1;
    rst_n = 1'b1;
    busIf.icache_miss = 1'b1;
    busIf.icache_miss_addr = 16'h1236;
    #1;
    runFill("imiss", 1'b0, 16'h1230, rangeMask(5, 12));

    // simultaneous misses: D first, then I in the IDLE cycle after D's DONE
    @(posedge clk); #1;
    busIf.icache_miss = 1'b1;
    busIf.icache_miss_addr = 16'h0040;
    busIf.dcache_miss = 1'b1;
    busIf.dcache_miss_addr = 16'h8008;
    #1;
    runFill("simD", 1'b1, 16'h8000, rangeMask(5, 12));
    runFill("simI", 1'b0, 16'h0040, rangeMask(3, 10));

    // stray valid while idle
    @(posedge clk); #1;
    busIf.mem_data_valid = 1'b1;
    #1;
    checkQuiet("stray");
    chk("stray_idx", 32'(busIf.fill_word_idx), 32'h0);

    // irregular valid gaps plus a stray valid after completion
    @(posedge clk); #1;
    busIf.mem_data_valid = 1'b0;
    busIf.icache_miss = 1'b1;
    busIf.icache_miss_addr = 16'h3456;
    #1;
    runFill("irreg", 1'b0, 16'h3450,
            rangeMask(3, 4) | rangeMask(7, 8) | rangeMask(10, 10) |
            rangeMask(14, 16) | rangeMask(18, 18));

    // reset in DRAIN after 3 received words, then restart
    @(posedge clk); #1;
    busIf.dcache_miss = 1'b1;
    busIf.dcache_miss_addr = 16'h2004;
    #1;
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      busIf.mem_data_valid = (c >= 9);
      #1;
    end
    chk("rstmid_we_w2", 32'(busIf.fill_we_d), 32'h1);
    chk("rstmid_idx_w2", 32'(busIf.fill_word_idx), 32'h2);
    @(posedge clk); #1;
    busIf.mem_data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rstmid_busy_drain", 32'(busIf.busy), 32'h1);
    chk("rstmid_tag_drain", 32'(busIf.fill_tag_we_d), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checkQuiet("rstmid_after");
    runFill("restart", 1'b1, 16'h2000, rangeMask(5, 12));

    // top-of-memory block must not wrap
    @(posedge clk); #1;
    busIf.dcache_miss = 1'b1;
    busIf.dcache_miss_addr = 16'hFFF2;
    #1;
    runFill("top", 1'b1, 16'hFFF0, rangeMask(5, 12));

    @(posedge clk); #2;
    checkQuiet("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
